// File: rtl/adc_drain_pkg.sv
// adc_drain_pkg: shared FSM state type, header default and frame-length helper.
// ADC_DRAIN_TRAILER_EN adds a TRAILER state carrying the XOR of the payload.
package adc_drain_pkg;
`ifdef ADC_DRAIN_TRAILER_EN
  typedef enum logic [2:0] {IDLE, HDR, SEQ, PAYLOAD, TRAILER, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, HDR, SEQ, PAYLOAD, DONE} state_e;
`endif

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  function automatic int unsigned frame_len(input int unsigned burst_len);
`ifdef ADC_DRAIN_TRAILER_EN
    return burst_len + 3;
`else
    return burst_len + 2;
`endif
  endfunction
endpackage

// File: rtl/drain_skid_buf.sv
// drain_skid_buf: 2-entry FIFO between the width-converter read port and the byte stream.
module drain_skid_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  input  logic       pop_ready,
  output logic       pop_valid,
  output logic [7:0] pop_data,
  output logic [1:0] occ
);
  logic [7:0] mem_q [2];
  logic       wr_q, rd_q;
  logic [1:0] cnt_q;
  logic       push, pop;

  assign pop_valid = cnt_q != 2'd0;
  assign pop_data  = pop_valid ? mem_q[rd_q] : 8'h00;
  assign occ       = cnt_q;
  assign pop       = pop_valid && pop_ready;
  assign push      = push_valid && (cnt_q != 2'd2 || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/adc_drain_ctrl.sv
// adc_drain_ctrl: drains ADC bytes from a FIFO into framed valid/ready bursts (header, sequence, payload).
// Define ADC_DRAIN_TRAILER_EN to append an XOR-of-payload trailer byte carrying m_last.
module adc_drain_ctrl
  import adc_drain_pkg::*;
#(
  parameter int unsigned BURST_LEN = 256,
  parameter logic [7:0]  HDR_BYTE  = HDR_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic        fifo_rd_full,
  input  logic        fifo_rd_rst_busy,
  output logic        fifo_rd_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        overflow,
  input  logic        clr_ovf
);
  localparam logic [15:0] BLEN     = 16'(BURST_LEN);
  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  state_e      state_q;
  logic [15:0] frame_cnt_q, issued_q, sent_q;
  logic [7:0]  xor_q, buf_data;
  logic        inflight_q, overflow_q, buf_valid;
  logic [1:0]  occ, occ_after;
  logic        fire, pay_fire, last_pay, is_trl;

  drain_skid_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push_valid(inflight_q),
    .push_data (fifo_dout),
    .pop_ready (m_ready && state_q == PAYLOAD),
    .pop_valid (buf_valid),
    .pop_data  (buf_data),
    .occ       (occ)
  );

`ifdef ADC_DRAIN_TRAILER_EN
  assign is_trl = state_q == TRAILER;
  assign m_last = is_trl;
`else
  assign is_trl = 1'b0;
  assign m_last = state_q == PAYLOAD && buf_valid && last_pay;
`endif

  assign fire      = m_valid && m_ready;
  assign pay_fire  = fire && state_q == PAYLOAD;
  assign last_pay  = sent_q == LAST_IDX;
  // Credit the byte leaving this cycle so a read can be issued every cycle at full rate.
  assign occ_after = occ - {1'b0, pay_fire};
  assign fifo_rd_en = !rst && state_q == PAYLOAD && !fifo_empty && !fifo_rd_rst_busy &&
                      issued_q < BLEN && (occ_after + {1'b0, inflight_q}) < 2'd2;
  assign m_valid   = state_q == HDR || state_q == SEQ || (state_q == PAYLOAD && buf_valid) || is_trl;
  assign m_data    = state_q == HDR ? HDR_BYTE :
                     state_q == SEQ ? frame_cnt_q[7:0] :
                     state_q == PAYLOAD ? buf_data :
                     is_trl ? xor_q : 8'h00;
  assign busy      = state_q != IDLE;
  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_cnt_q <= 16'd0;
      issued_q    <= 16'd0;
      sent_q      <= 16'd0;
      xor_q       <= 8'h00;
      inflight_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      overflow_q <= fifo_rd_full || (overflow_q && !clr_ovf);
      if (fifo_rd_en) issued_q <= issued_q + 16'd1;
      if (pay_fire) begin
        sent_q <= sent_q + 16'd1;
        xor_q  <= xor_q ^ m_data;
      end
      case (state_q)
        IDLE:    if (enable && !fifo_rd_rst_busy) state_q <= HDR;
        HDR:     if (fire) state_q <= SEQ;
        SEQ:     if (fire) state_q <= PAYLOAD;
`ifdef ADC_DRAIN_TRAILER_EN
        PAYLOAD: if (pay_fire && last_pay) state_q <= TRAILER;
        TRAILER: if (fire) state_q <= DONE;
`else
        PAYLOAD: if (pay_fire && last_pay) state_q <= DONE;
`endif
        DONE: begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
          issued_q    <= 16'd0;
          sent_q      <= 16'd0;
          xor_q       <= 8'h00;
          state_q     <= enable ? HDR : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_drain_ctrl.sv
// tb_adc_drain_ctrl: randomized scoreboard bench with a queue-based FIFO model and frame-level reference.
module tb_adc_drain_ctrl;
  import adc_drain_pkg::*;

  localparam int BL = 4;
  localparam logic [7:0] HB = 8'hA5;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty = 1'b1, fifo_rd_full = 1'b0, fifo_rd_rst_busy = 1'b0, clr_ovf = 1'b0;
  logic        fifo_rd_en, m_valid, m_last, busy, overflow;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic [15:0] frame_cnt;

  adc_drain_ctrl #(.BURST_LEN(BL), .HDR_BYTE(HB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_full(fifo_rd_full), .fifo_rd_rst_busy(fifo_rd_rst_busy), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .frame_cnt(frame_cnt), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] fq[$];
  int rd_cnt = 0, acc_cnt = 0;
  logic [15:0] exp_seq = 16'd0;
  int rdy_mode = 0, gap_mode = 0, rb_mode = 0;
  logic rd_s = 1'b0, gap = 1'b0;
  logic stall_q = 1'b0, pl = 1'b0;
  logic [7:0] pd = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // FIFO model: read strobe seen at negedge, data presented one cycle after the strobe.
  always @(negedge clk) rd_s = fifo_rd_en;
  always @(posedge clk) begin
    if (rd_s) begin
      chk("rd_nonempty", fq.size() != 0, 1);
      if (fq.size() != 0) fifo_dout <= fq.pop_front();
      rd_cnt++;
    end
    #1;
    m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~m_ready : 1'($urandom_range(0, 1));
    gap = gap_mode != 0 && $urandom_range(0, 3) == 0;
    fifo_rd_rst_busy = rb_mode != 0 && $urandom_range(0, 9) == 0;
    #1 fifo_empty = fq.size() == 0 || gap;
  end

  // Monitor: pops the scoreboard on every accepted transfer and checks hold-while-stalled.
  always @(negedge clk) begin
    logic [8:0] e;
    if (stall_q) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, pd);
      chk("stall_last", m_last, pl);
    end
    if (m_valid && m_ready && !rst) begin
      if (exp_q.size() == 0) chk("unexpected_byte", m_data, 9'h1FF);
      else begin
        e = exp_q.pop_front();
        chk("byte_data", m_data, e[7:0]);
        chk("byte_last", m_last, e[8]);
        acc_cnt++;
      end
    end
    stall_q = m_valid && !m_ready && !rst;
    pd = m_data;
    pl = m_last;
  end

  task automatic push_frame(input logic [7:0] p [BL]);
    logic [7:0] x = 8'h00;
    int total = int'(frame_len(BL));
    for (int i = 0; i < BL; i++) x ^= p[i];
    for (int i = 0; i < total; i++)
      exp_q.push_back({i == total - 1, i == 0 ? HB : i == 1 ? exp_seq[7:0] : i < BL + 2 ? p[i - 2] : x});
    exp_seq++;
  endtask

  task automatic fifo_load(input logic [7:0] p [BL], input int from, input int to);
    for (int i = from; i < to; i++) fq.push_back(p[i]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    int n = 0;
    enable = 1'b1;
    do begin cyc(); n++; end while (!busy && n < 200);
    enable = 1'b0;
    chk("start_timeout", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin cyc(); n++; end
    chk("frame_done_timeout", exp_q.size() == 0 && !busy, 1);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 500) begin cyc(); n++; end
    chk("acc_timeout", acc_cnt >= target, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    exp_q.delete();
    fq.delete();
    exp_seq = 16'd0;
  endtask

  initial begin
    logic [7:0] p [BL];
    logic [7:0] p2 [BL];
    int r0, base, gap_bad;
    fifo_rd_full = 1'b1;
    cyc();
    fifo_rd_full = 1'b0;
    do_reset();

    // Basic frame, m_ready held high.
    p = '{8'h11, 8'h22, 8'h33, 8'h44};
    r0 = rd_cnt;
    push_frame(p);
    fifo_load(p, 0, BL);
    start_frame();
    wait_idle();
    chk("a_frame_cnt", frame_cnt, exp_seq);
    chk("a_rd_count", rd_cnt - r0, BL);

    // Same frame with m_ready toggling every cycle.
    rdy_mode = 1;
    r0 = rd_cnt;
    push_frame(p);
    fifo_load(p, 0, BL);
    start_frame();
    wait_idle();
    chk("b_frame_cnt", frame_cnt, exp_seq);
    chk("b_rd_count", rd_cnt - r0, BL);
    rdy_mode = 0;

    // FIFO runs dry after two payload bytes for ten cycles.
    for (int i = 0; i < BL; i++) p[i] = 8'($urandom);
    r0 = rd_cnt;
    base = acc_cnt;
    push_frame(p);
    fifo_load(p, 0, 2);
    start_frame();
    wait_acc(base + 4);
    gap_bad = 0;
    repeat (10) begin
      cyc();
      if (m_valid) gap_bad++;
    end
    chk("c_gap_valid_low", gap_bad, 0);
    chk("c_gap_busy", busy, 1);
    fifo_load(p, 2, BL);
    wait_idle();
    chk("c_rd_count", rd_cnt - r0, BL);

    // Back-to-back frames with enable held high.
    do_reset();
    p  = '{8'h01, 8'h02, 8'h03, 8'h04};
    p2 = '{8'h05, 8'h06, 8'h07, 8'h08};
    r0 = rd_cnt;
    push_frame(p);
    push_frame(p2);
    fifo_load(p, 0, BL);
    fifo_load(p2, 0, BL);
    enable = 1'b1;
    for (int n = 0; n < 500 && frame_cnt != 16'd1; n++) cyc();
    enable = 1'b0;
    wait_idle();
    chk("d_frame_cnt", frame_cnt, 2);
    chk("d_rd_count", rd_cnt - r0, 2 * BL);

    // Sticky overflow: set wins over a simultaneous clear.
    fifo_rd_full = 1'b1;
    clr_ovf = 1'b1;
    cyc();
    fifo_rd_full = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    cyc();
    chk("ovf_cleared", overflow, 0);
    clr_ovf = 1'b0;
    fifo_rd_full = 1'b1;
    cyc();
    fifo_rd_full = 1'b0;
    repeat (3) cyc();
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;

    // Reset mid-frame after two payload bytes.
    for (int i = 0; i < BL; i++) p[i] = 8'($urandom);
    base = acc_cnt;
    push_frame(p);
    fifo_load(p, 0, BL);
    start_frame();
    wait_acc(base + 4);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", m_data, 0);
    rst = 1'b0;
    exp_q.delete();
    fq.delete();
    exp_seq = 16'd0;
    gap_bad = 0;
    repeat (5) begin
      cyc();
      if (m_valid || fifo_rd_en) gap_bad++;
    end
    chk("mid_rst_quiet", gap_bad, 0);
    for (int i = 0; i < BL; i++) p[i] = 8'($urandom);
    push_frame(p);
    fifo_load(p, 0, BL);
    start_frame();
    wait_idle();
    chk("e_frame_cnt", frame_cnt, 1);

    // Randomized back-pressure, FIFO gaps and read-reset-busy pulses.
    rdy_mode = 2;
    gap_mode = 1;
    rb_mode = 1;
    r0 = rd_cnt;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < BL; i++) p[i] = 8'($urandom);
      push_frame(p);
      fifo_load(p, 0, BL);
      start_frame();
      wait_idle();
    end
    chk("r_frame_cnt", frame_cnt, exp_seq);
    chk("r_rd_count", rd_cnt - r0, 8 * BL);
    rdy_mode = 0;
    gap_mode = 0;
    rb_mode = 0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
